// File: rtl/register_unit.sv
// register_unit: multi-mode data register (hold, clear, parallel load,
// serial load from either end, logical shifts) selected per cycle by ctrl.
// Optional build macro: REGISTER_ROTATE_EN turns opcode 7 into rotate-left;
// without it opcode 7 holds, same as NONE.
module register_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic [2:0]       ctrl,
    input  logic             serial_data_input,
    input  logic [WIDTH-1:0] parallel_data_input,
    output logic [WIDTH-1:0] data_output
);

    typedef enum logic [2:0] {
        OP_NONE                = 3'd0,
        OP_CLR                 = 3'd1,
        OP_PARALLEL_LOAD       = 3'd2,
        OP_SERIAL_MSB_LOAD     = 3'd3,
        OP_SERIAL_LSB_LOAD     = 3'd4,
        OP_SHIFT_LOGICAL_LEFT  = 3'd5,
        OP_SHIFT_LOGICAL_RIGHT = 3'd6,
        OP_RESERVED            = 3'd7
    } op_e;

    op_e              op;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;

    assign op          = op_e'(ctrl);
    assign data_output = reg_q;

    // Next-state decode: every opcode not listed (or unknown) holds contents
    always_comb begin
        reg_d = reg_q;
        case (op)
            OP_NONE:                reg_d = reg_q;
            OP_CLR:                 reg_d = '0;
            OP_PARALLEL_LOAD:       reg_d = parallel_data_input;
            OP_SERIAL_MSB_LOAD:     reg_d = {serial_data_input, reg_q[WIDTH-1:1]};
            OP_SERIAL_LSB_LOAD:     reg_d = {reg_q[WIDTH-2:0], serial_data_input};
            OP_SHIFT_LOGICAL_LEFT:  reg_d = {reg_q[WIDTH-2:0], 1'b0};
            OP_SHIFT_LOGICAL_RIGHT: reg_d = {1'b0, reg_q[WIDTH-1:1]};
`ifdef REGISTER_ROTATE_EN
            OP_RESERVED:            reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
`else
            OP_RESERVED:            reg_d = reg_q;
`endif
            default:                reg_d = reg_q;
        endcase
    end

    // Storage flops; asynchronous active-low clear overrides any operation
    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            reg_q <= '0;
        end else begin
            reg_q <= reg_d;
        end
    end

endmodule

// File: tb/tb_register_unit.sv
// tb_register_unit: scoreboard bench for register_unit. Stimulus drives inputs
// on the falling edge and queues the expected contents; a monitor pops and
// compares a quarter period after each rising edge.
`timescale 1ns/1ps
module tb_register_unit;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         async_nreset;
    logic [2:0]   ctrl;
    logic         serial_data_input;
    logic [W-1:0] parallel_data_input;
    logic [W-1:0] data_output;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] exp;
        int           id;
    } sb_item_t;

    sb_item_t     exp_q[$];
    logic [W-1:0] model;
    int           op_id = 0;

    register_unit #(.WIDTH(W)) dut (
        .clk                 (clk),
        .async_nreset        (async_nreset),
        .ctrl                (ctrl),
        .serial_data_input   (serial_data_input),
        .parallel_data_input (parallel_data_input),
        .data_output         (data_output)
    );

    always #10 clk = ~clk;

    // Reference model written arithmetically, independent of the RTL decode
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] r, input logic [2:0] c,
                                              input logic s, input logic [W-1:0] p);
        logic [W:0] wide;
        wide = {1'b0, r};
        if (c == 3'd1) return '0;
        if (c == 3'd2) return p;
        if (c == 3'd3) return (r >> 1) | (s ? 8'h80 : 8'h00);
        if (c == 3'd4) begin wide = (wide << 1) | {8'h00, s}; return wide[W-1:0]; end
        if (c == 3'd5) begin wide = wide << 1; return wide[W-1:0]; end
        if (c == 3'd6) return r / 2;
`ifdef REGISTER_ROTATE_EN
        if (c == 3'd7) begin wide = wide << 1; return wide[W-1:0] | (r / 128); end
`endif
        return r;
    endfunction

    task automatic check_now(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Directed op: hand-computed expected value is queued for the monitor
    task automatic op_exp(input logic [2:0] c, input logic s, input logic [W-1:0] p,
                          input logic [W-1:0] exp);
        sb_item_t it;
        @(negedge clk);
        ctrl = c; serial_data_input = s; parallel_data_input = p;
        op_id++;
        it.exp = exp; it.id = op_id;
        exp_q.push_back(it);
        model = exp;
        @(posedge clk);
    endtask

    // Random op: expected value comes from the reference model
    task automatic op_rand();
        logic [2:0]   c;
        logic         s;
        logic [W-1:0] p;
        c = 3'($urandom_range(0, 7));
        s = 1'($urandom_range(0, 1));
        p = 8'($urandom);
        op_exp(c, s, p, ref_next(model, c, s, p));
    endtask

    // Monitor: compare queued expectation a quarter period after each rising edge
    initial begin
        sb_item_t it;
        forever begin
            @(posedge clk);
            #5;
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                total++;
                if (data_output !== it.exp) begin
                    bad++;
                    $display("FAIL op%0d: got %h expected %h", it.id, data_output, it.exp);
                end
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        async_nreset = 1'b0;
        ctrl = 3'd0; serial_data_input = 1'b0; parallel_data_input = '0;
        model = '0;
        #7;
        check_now("reset_state", data_output, 8'h00);
        @(negedge clk);
        async_nreset = 1'b1;

        // Async reset mid-cycle with contents A5, and reset overriding a load
        op_exp(3'd2, 1'b0, 8'hA5, 8'hA5);
        #7;
        async_nreset = 1'b0;
        #1;
        check_now("async_reset_midcycle", data_output, 8'h00);
        ctrl = 3'd2; parallel_data_input = 8'hFF;
        @(posedge clk); #5;
        check_now("reset_overrides_load", data_output, 8'h00);
        @(negedge clk);
        ctrl = 3'd0;
        async_nreset = 1'b1;
        model = '0;

        // Parallel load, hold, clear
        op_exp(3'd2, 1'b1, 8'h3C, 8'h3C);
        op_exp(3'd0, 1'b1, 8'hFF, 8'h3C);
        op_exp(3'd0, 1'b0, 8'h00, 8'h3C);
        op_exp(3'd0, 1'b1, 8'h55, 8'h3C);
        op_exp(3'd1, 1'b1, 8'hFF, 8'h00);

        // Serial LSB-side load 1,0,1,1
        op_exp(3'd4, 1'b1, 8'hFF, 8'h01);
        op_exp(3'd4, 1'b0, 8'hFF, 8'h02);
        op_exp(3'd4, 1'b1, 8'h00, 8'h05);
        op_exp(3'd4, 1'b1, 8'h00, 8'h0B);

        // Serial MSB-side load 1,1 from zero
        op_exp(3'd1, 1'b0, 8'h00, 8'h00);
        op_exp(3'd3, 1'b1, 8'h00, 8'h80);
        op_exp(3'd3, 1'b1, 8'hFF, 8'hC0);

        // Logical shifts discard the shifted-out bit
        op_exp(3'd2, 1'b0, 8'h81, 8'h81);
        op_exp(3'd5, 1'b1, 8'hFF, 8'h02);
        op_exp(3'd2, 1'b0, 8'h81, 8'h81);
        op_exp(3'd6, 1'b1, 8'hFF, 8'h40);
        op_exp(3'd2, 1'b0, 8'h80, 8'h80);
        op_exp(3'd5, 1'b1, 8'h00, 8'h00);

        // Opcode 7
        op_exp(3'd2, 1'b0, 8'h81, 8'h81);
`ifdef REGISTER_ROTATE_EN
        op_exp(3'd7, 1'b1, 8'hFF, 8'h03);
`else
        op_exp(3'd7, 1'b1, 8'hFF, 8'h81);
`endif

        // Random regression against the reference model
        for (int i = 0; i < 1000; i++) op_rand();

        @(negedge clk);
        @(posedge clk); #6;
        check_now("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
